// File: rtl/paddle_ctrl_pkg.sv
// Shared pong definitions: screen geometry, coordinate widths, paddle mode enum.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package paddle_ctrl_pkg;

    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    typedef logic [X_W-1:0] xpos_t;
    typedef logic [Y_W-1:0] ypos_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYER    = 2'd1,
        AI_TRACK  = 2'd2,
        AI_RETURN = 2'd3
    } pad_state_t;

    // Mode chosen from the control inputs sampled on a frame tick.
    function automatic pad_state_t decide_state(input logic play_en,
                                                input logic ai_ctrl,
                                                input logic ball_toward);
        pad_state_t st;
        if (!play_en)         st = IDLE;
        else if (!ai_ctrl)    st = PLAYER;
        else if (ball_toward) st = AI_TRACK;
        else                  st = AI_RETURN;
        return st;
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle control bundle: frame/mode/button/ball inputs and paddle position outputs.
// Latency: n/a (wires only).
// Backpressure: none; master drives controls, slave (the paddle) drives position.
interface paddle_ctrl_if;
    import paddle_ctrl_pkg::*;

    logic  frame_tick;
    logic  play_en;
    logic  ai_ctrl;
    logic  btn_up;
    logic  btn_down;
    ypos_t ball_y;
    logic  ball_toward;
    xpos_t outX;
    ypos_t outY;
    logic  moving;
    logic  dir_down;
    logic  at_limit;

    modport master (
        output frame_tick, play_en, ai_ctrl, btn_up, btn_down, ball_y, ball_toward,
        input  outX, outY, moving, dir_down, at_limit
    );

    modport slave (
        input  frame_tick, play_en, ai_ctrl, btn_up, btn_down, ball_y, ball_toward,
        output outX, outY, moving, dir_down, at_limit
    );

endinterface

// File: rtl/paddle_ai_target.sv
// AI helper: ball_y lag line, clamped target, dead-zone compare and step size.
// Latency: lag line advances per frame_tick; move/down/step are combinational.
// Backpressure: none; lag line shifts on every frame_tick regardless of mode.
//
// Ports: clk/reset; frame_tick shifts the lag line; ball_y is sampled into it;
// track selects ball tracking (1) or return-to-centre (0); pos is the current
// paddle Y. Outputs: move (outside dead zone), down (target below), step.
module paddle_ai_target
    import paddle_ctrl_pkg::*;
#(
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int PAD_LEN     = 64,
    parameter int SPEED       = 4,
    parameter int AI_LAG      = 2,
    parameter int AI_DEADZONE = 8
)(
    input  logic  clk,
    input  logic  reset,
    input  logic  frame_tick,
    input  ypos_t ball_y,
    input  logic  track,
    input  ypos_t pos,
    output logic  move,
    output logic  down,
    output ypos_t step
);

    localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - PAD_LEN);
    localparam logic signed [11:0] Y_CTR = 12'((SCREEN_H - PAD_LEN) / 2);
    localparam logic signed [11:0] HALF  = 12'(PAD_LEN / 2);
    localparam logic signed [11:0] DZ    = 12'(AI_DEADZONE);
    localparam logic signed [11:0] SPD   = 12'(SPEED);
    localparam ypos_t LAG_INIT = ypos_t'(SCREEN_H / 2);

    // lag_q[AI_LAG-1] is the sample taken AI_LAG ticks ago.
    ypos_t lag_q [AI_LAG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < AI_LAG; i++) lag_q[i] <= LAG_INIT;
        end else if (frame_tick) begin
            lag_q[0] <= ball_y;
            for (int i = 1; i < AI_LAG; i++) lag_q[i] <= lag_q[i-1];
        end
    end

    logic signed [11:0] raw, tgt, diff, mag;

    // Widened signed maths so a ball near the top cannot wrap the target.
    always_comb begin
        raw = $signed({3'b000, lag_q[AI_LAG-1]}) - HALF;
        if (!track)          tgt = Y_CTR;
        else if (raw < 0)    tgt = '0;
        else if (raw > Y_MAX) tgt = Y_MAX;
        else                 tgt = raw;
        diff = tgt - $signed({3'b000, pos});
        mag  = (diff < 0) ? -diff : diff;
        move = (mag > DZ);
        down = (diff > 0);
        step = (mag > SPD) ? ypos_t'(SPD) : ypos_t'(mag);
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: player ramp or lagged AI, saturating Y register.
// Latency: outputs update on the clk edge sampling frame_tick=1 (visible next cycle).
// Backpressure: none; state advances only on frame_tick, holds otherwise.
//
// Ports: clk, reset (sync, active-high); bus (slave) carries frame_tick,
// play_en, ai_ctrl, btn_up/btn_down, ball_y, ball_toward in and
// outX/outY/moving/dir_down/at_limit out.
module paddle_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int PAD_W       = 8,
    parameter int PAD_LEN     = 64,
    parameter int LEFT        = 1,
    parameter int SPEED       = 4,
    parameter int AI_LAG      = 2,
    parameter int AI_DEADZONE = 8
)(
    input  logic        clk,
    input  logic        reset,
    paddle_ctrl_if.slave bus
);

    localparam int Y_MAX_I = SCREEN_H - PAD_LEN;
    localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX_I);
    localparam ypos_t Y_MAX_P  = ypos_t'(Y_MAX_I);
    localparam ypos_t Y_CTR_P  = ypos_t'(Y_MAX_I / 2);
    localparam xpos_t X_POS    = xpos_t'((LEFT != 0) ? 0 : SCREEN_W - PAD_W);
    localparam ypos_t STEP_ONE = ypos_t'(1);
    localparam ypos_t STEP_MAX = ypos_t'(SPEED);

    pad_state_t state_q, state_d;
    ypos_t step_q, step_d, eff_step, mv_amt;
    logic  last_down_q, last_down_d;
    logic  mv_en, mv_down;
    xpos_t x_q;
    ypos_t y_q, new_y;
    logic  moving_q, dir_q, limit_q, changed;
    logic  ai_move, ai_down;
    ypos_t ai_step;
    logic signed [11:0] pos_w, y_s, amt_s;

    assign state_d = decide_state(bus.play_en, bus.ai_ctrl, bus.ball_toward);

    paddle_ai_target #(
        .SCREEN_H    (SCREEN_H),
        .PAD_LEN     (PAD_LEN),
        .SPEED       (SPEED),
        .AI_LAG      (AI_LAG),
        .AI_DEADZONE (AI_DEADZONE)
    ) u_ai (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (bus.frame_tick),
        .ball_y     (bus.ball_y),
        .track      (state_d == AI_TRACK),
        .pos        (y_q),
        .move       (ai_move),
        .down       (ai_down),
        .step       (ai_step)
    );

    always_comb begin
        mv_en       = 1'b0;
        mv_down     = 1'b0;
        mv_amt      = '0;
        eff_step    = step_q;
        step_d      = STEP_ONE;
        last_down_d = last_down_q;
        case (state_d)
            PLAYER: begin
                if (bus.btn_up != bus.btn_down) begin
                    // A fresh press or a direction reversal restarts the ramp at 1.
                    eff_step = (state_q != PLAYER || bus.btn_down != last_down_q)
                               ? STEP_ONE : step_q;
                    mv_en       = 1'b1;
                    mv_down     = bus.btn_down;
                    mv_amt      = eff_step;
                    step_d      = (eff_step >= STEP_MAX) ? STEP_MAX : eff_step + STEP_ONE;
                    last_down_d = bus.btn_down;
                end
            end
            AI_TRACK, AI_RETURN: begin
                mv_en   = ai_move;
                mv_down = ai_down;
                mv_amt  = ai_step;
            end
            default: ;
        endcase

        y_s   = $signed({3'b000, y_q});
        amt_s = $signed({3'b000, mv_amt});
        if (!mv_en)       pos_w = y_s;
        else if (mv_down) pos_w = y_s + amt_s;
        else              pos_w = y_s - amt_s;

        if (pos_w < 0)            new_y = '0;
        else if (pos_w > Y_MAX_S) new_y = Y_MAX_P;
        else                      new_y = pos_w[Y_W-1:0];

        // A clipped move only counts if the paddle really moved.
        changed = (new_y != y_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= STEP_ONE;
            last_down_q <= 1'b0;
            x_q         <= X_POS;
            y_q         <= Y_CTR_P;
            moving_q    <= 1'b0;
            dir_q       <= 1'b0;
            limit_q     <= (Y_CTR_P == '0) || (Y_CTR_P == Y_MAX_P);
        end else if (bus.frame_tick) begin
            state_q     <= state_d;
            step_q      <= step_d;
            last_down_q <= last_down_d;
            y_q         <= new_y;
            moving_q    <= changed;
            if (changed) dir_q <= (new_y > y_q);
            limit_q     <= (new_y == '0) || (new_y == Y_MAX_P);
        end
    end

    assign bus.outX     = x_q;
    assign bus.outY     = y_q;
    assign bus.moving   = moving_q;
    assign bus.dir_down = dir_q;
    assign bus.at_limit = limit_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed scenarios plus randomized play, all scored
// against a frame-level behavioural model (run-length ramp, queue lag line).
module tb_paddle_ctrl;
    import paddle_ctrl_pkg::*;

    localparam int SPEED = 4;
    localparam int LAG   = 2;
    localparam int DZ    = 8;
    localparam int YMAX  = 416;
    localparam int YCTR  = 208;
    localparam int HALF  = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    paddle_ctrl_if if_l();
    paddle_ctrl_if if_r();

    paddle_ctrl #(.SCREEN_W(640), .SCREEN_H(480), .PAD_W(8), .PAD_LEN(64), .LEFT(1),
                  .SPEED(SPEED), .AI_LAG(LAG), .AI_DEADZONE(DZ))
        u_dut_l (.clk(clk), .reset(reset), .bus(if_l));

    paddle_ctrl #(.SCREEN_W(640), .SCREEN_H(480), .PAD_W(8), .PAD_LEN(64), .LEFT(0),
                  .SPEED(SPEED), .AI_LAG(LAG), .AI_DEADZONE(DZ))
        u_dut_r (.clk(clk), .reset(reset), .bus(if_r));

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_y;
    bit m_mov, m_dir, m_lim;
    int run, prev_press;
    int lagq[$];

    task automatic model_reset();
        m_y = YCTR; m_mov = 0; m_dir = 0; m_lim = 0;
        run = 0; prev_press = 0;
        lagq.delete();
        for (int i = 0; i < LAG; i++) lagq.push_back(240);
    endtask

    // One frame: player step = min(length of current single-button run, SPEED).
    task automatic model_tick();
        int lagged, press, delta, target, d, ad, ny;
        lagged = lagq[0];
        lagq.delete(0);
        lagq.push_back(int'(if_l.ball_y));
        press = 0; delta = 0;
        if (if_l.play_en) begin
            if (!if_l.ai_ctrl) begin
                if (if_l.btn_up != if_l.btn_down) begin
                    press = if_l.btn_down ? 1 : -1;
                    run   = (press == prev_press) ? run + 1 : 1;
                    delta = press * ((run < SPEED) ? run : SPEED);
                end
            end else begin
                if (if_l.ball_toward) begin
                    target = lagged - HALF;
                    if (target < 0) target = 0;
                    if (target > YMAX) target = YMAX;
                end else begin
                    target = YCTR;
                end
                d  = target - m_y;
                ad = (d < 0) ? -d : d;
                if (ad > DZ) delta = ((d > 0) ? 1 : -1) * ((ad < SPEED) ? ad : SPEED);
            end
        end
        prev_press = press;
        ny = m_y + delta;
        if (ny < 0) ny = 0;
        if (ny > YMAX) ny = YMAX;
        m_mov = (ny != m_y);
        if (m_mov) m_dir = (ny > m_y);
        m_y   = ny;
        m_lim = (ny == 0) || (ny == YMAX);
    endtask

    task automatic do_tick();
        @(negedge clk);
        if_l.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        if_l.frame_tick = 1'b0;
        model_tick();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic set_in(input bit pe, input bit ai, input bit up, input bit dn,
                          input int by, input bit tw);
        if_l.play_en = pe; if_l.ai_ctrl = ai; if_l.btn_up = up; if_l.btn_down = dn;
        if_l.ball_y = 9'(by); if_l.ball_toward = tw;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (if_l.outX !== 10'd0) begin bad++; $display("FAIL reset_x_left got=%0d want=0", if_l.outX); end
        total++;
        if (if_r.outX !== 10'd632) begin bad++; $display("FAIL reset_x_right got=%0d want=632", if_r.outX); end
        total++;
        if ({if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit} !== {9'd208, 3'b000}) begin
            bad++; $display("FAIL reset_left got y=%0d mv=%0b dn=%0b lim=%0b want y=208 0 0 0",
                            if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit);
        end
        total++;
        if ({if_r.outY, if_r.moving, if_r.at_limit} !== {9'd208, 2'b00}) begin
            bad++; $display("FAIL reset_right got y=%0d mv=%0b lim=%0b want y=208 0 0",
                            if_r.outY, if_r.moving, if_r.at_limit);
        end
    endtask

    task automatic test_idle_hold();
        set_in(0, 0, 1, 0, 100, 1);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            total++;
            if ({if_l.outY, if_l.moving} !== {9'(m_y), m_mov} || if_l.outY !== 9'd208) begin
                bad++; $display("FAIL idle_tick%0d got y=%0d mv=%0b want y=%0d mv=%0b", i, if_l.outY, if_l.moving, m_y, m_mov);
            end
        end
        // No tick: mode and buttons wiggle but nothing may move.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(1, i[0], 1, 0, 400, 1);
        end
        @(posedge clk); #1;
        total++;
        if (if_l.outY !== 9'(m_y) || if_l.moving !== 1'b0) begin
            bad++; $display("FAIL no_tick_hold got y=%0d mv=%0b want y=%0d mv=0", if_l.outY, if_l.moving, m_y);
        end
    endtask

    task automatic test_player_ramp();
        apply_reset();
        set_in(1, 0, 1, 0, 240, 0);
        for (int i = 0; i < 10; i++) begin
            do_tick();
            total++;
            if ({if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit} !== {9'(m_y), m_mov, m_dir, m_lim}) begin
                bad++; $display("FAIL ramp_up_tick%0d got y=%0d mv=%0b dn=%0b lim=%0b want y=%0d mv=%0b dn=%0b lim=%0b",
                    i, if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit, m_y, m_mov, m_dir, m_lim);
            end
        end
        total++;
        if (if_l.outY !== 9'd174) begin bad++; $display("FAIL ramp_up_end got=%0d want=174", if_l.outY); end
        set_in(1, 0, 0, 1, 240, 0);
        do_tick();
        total++;
        if ({if_l.outY, if_l.moving, if_l.dir_down} !== {9'd175, 1'b1, 1'b1}) begin
            bad++; $display("FAIL reversal got y=%0d mv=%0b dn=%0b want y=175 mv=1 dn=1", if_l.outY, if_l.moving, if_l.dir_down);
        end
    endtask

    task automatic test_limit();
        int exp_y [4];
        bit exp_mv [4];
        bit exp_lim [4];
        exp_y = '{411, 413, 416, 416};
        exp_mv = '{1, 1, 1, 0};
        exp_lim = '{0, 0, 1, 1};
        apply_reset();
        set_in(1, 0, 0, 1, 240, 0);
        for (int i = 0; i < 52; i++) do_tick();
        total++;
        if (if_l.outY !== 9'd410 || if_l.outY !== 9'(m_y)) begin
            bad++; $display("FAIL approach_410 got=%0d want=410 model=%0d", if_l.outY, m_y);
        end
        set_in(1, 0, 0, 0, 240, 0);
        do_tick();
        set_in(1, 0, 0, 1, 240, 0);
        for (int i = 0; i < 4; i++) begin
            do_tick();
            total++;
            if ({if_l.outY, if_l.moving, if_l.at_limit} !== {9'(exp_y[i]), exp_mv[i], exp_lim[i]} ||
                {if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit} !== {9'(m_y), m_mov, m_dir, m_lim}) begin
                bad++; $display("FAIL limit_tick%0d got y=%0d mv=%0b lim=%0b want y=%0d mv=%0b lim=%0b",
                    i, if_l.outY, if_l.moving, if_l.at_limit, exp_y[i], exp_mv[i], exp_lim[i]);
            end
        end
        set_in(1, 0, 1, 1, 240, 0);
        for (int i = 0; i < 2; i++) begin
            do_tick();
            total++;
            if ({if_l.outY, if_l.moving, if_l.dir_down} !== {9'd416, 1'b0, 1'b1}) begin
                bad++; $display("FAIL both_btn_tick%0d got y=%0d mv=%0b dn=%0b want y=416 mv=0 dn=1",
                    i, if_l.outY, if_l.moving, if_l.dir_down);
            end
        end
        set_in(1, 0, 1, 0, 240, 0);
        do_tick();
        total++;
        if ({if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit} !== {9'd415, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL leave_limit got y=%0d mv=%0b dn=%0b lim=%0b want y=415 1 0 0",
                if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit);
        end
    endtask

    task automatic test_ai_track();
        apply_reset();
        set_in(1, 1, 0, 0, 400, 1);
        for (int i = 0; i < 45; i++) begin
            do_tick();
            total++;
            if ({if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit} !== {9'(m_y), m_mov, m_dir, m_lim} ||
                (i < 2 && if_l.outY !== 9'd208)) begin
                bad++; $display("FAIL ai_track_tick%0d got y=%0d mv=%0b want y=%0d mv=%0b", i, if_l.outY, if_l.moving, m_y, m_mov);
            end
        end
        total++;
        if (if_l.outY !== 9'd360 || if_l.moving !== 1'b0) begin
            bad++; $display("FAIL ai_track_stop got y=%0d mv=%0b want y=360 mv=0", if_l.outY, if_l.moving);
        end
    endtask

    task automatic test_deadzone();
        apply_reset();
        set_in(1, 1, 0, 0, 250, 1);
        for (int i = 0; i < 4; i++) do_tick();
        total++;
        if (if_l.outY !== 9'd212 || if_l.outY !== 9'(m_y) || if_l.moving !== 1'b0) begin
            bad++; $display("FAIL deadzone_track got y=%0d mv=%0b want y=212 mv=0", if_l.outY, if_l.moving);
        end
        set_in(1, 1, 0, 0, 250, 0);
        for (int i = 0; i < 3; i++) do_tick();
        total++;
        if (if_l.outY !== 9'd212 || if_l.moving !== 1'b0) begin
            bad++; $display("FAIL deadzone_return got y=%0d mv=%0b want y=212 mv=0", if_l.outY, if_l.moving);
        end
    endtask

    task automatic test_reset_mid_move();
        apply_reset();
        set_in(1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) do_tick();
        @(negedge clk);
        reset = 1'b1;
        if_l.frame_tick = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        if_l.frame_tick = 1'b0;
        model_reset();
        total++;
        if ({if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit} !== {9'd208, 3'b000}) begin
            bad++; $display("FAIL reset_with_tick got y=%0d mv=%0b dn=%0b lim=%0b want y=208 0 0 0",
                if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit);
        end
        // A reloaded lag line (240 -> target 208) keeps the paddle still.
        set_in(1, 1, 0, 0, 400, 1);
        for (int i = 0; i < 2; i++) begin
            do_tick();
            total++;
            if ({if_l.outY, if_l.moving} !== {9'd208, 1'b0} || if_l.outY !== 9'(m_y)) begin
                bad++; $display("FAIL lag_reload_tick%0d got y=%0d mv=%0b want y=208 mv=0", i, if_l.outY, if_l.moving);
            end
        end
    endtask

    task automatic test_random();
        bit pe, ai, up, dn, tw;
        int by;
        pe = 1; ai = 0; up = 0; dn = 0; tw = 1; by = 240;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) apply_reset();
            pe = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) ai = ~ai;
            if ($urandom_range(0, 3) == 0) begin up = 1'($urandom); dn = 1'($urandom); end
            if ($urandom_range(0, 5) == 0) tw = ~tw;
            by = $urandom_range(0, 479);
            // Optional idle gap with scrambled inputs that must be ignored.
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 479), 1'($urandom));
                @(posedge clk); #1;
            end
            set_in(pe, ai, up, dn, by, tw);
            do_tick();
            total++;
            if ({if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit} !== {9'(m_y), m_mov, m_dir, m_lim}) begin
                bad++; $display("FAIL random_tick%0d got y=%0d mv=%0b dn=%0b lim=%0b want y=%0d mv=%0b dn=%0b lim=%0b",
                    n, if_l.outY, if_l.moving, if_l.dir_down, if_l.at_limit, m_y, m_mov, m_dir, m_lim);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        if_l.frame_tick = 1'b0;
        set_in(0, 0, 0, 0, 240, 0);
        if_r.frame_tick = 1'b0; if_r.play_en = 1'b0; if_r.ai_ctrl = 1'b0;
        if_r.btn_up = 1'b0; if_r.btn_down = 1'b0; if_r.ball_y = 9'd240; if_r.ball_toward = 1'b0;
        model_reset();

        test_reset();
        test_idle_hold();
        test_player_ramp();
        test_limit();
        test_ai_track();
        test_deadzone();
        test_reset_mid_move();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Parametrised paddle position controller for the pong playfield, replacing the fixed-geometry paddle block. It tracks one paddle's upper-left corner and advances it once per video frame, either from player buttons with a speed ramp or from a built-in AI with reaction lag and a dead zone. Its outputs feed the renderer and the collision logic directly.

## Interface
- SCREEN_W, 640: playfield width in pixels.
- SCREEN_H, 480: playfield height in pixels.
- PAD_W, 8: paddle width in pixels.
- PAD_LEN, 64: paddle length in pixels.
- LEFT, 1: 1 places the paddle at the left edge, 0 at the right edge.
- SPEED, 4: maximum step per frame in pixels, ≥1.
- AI_LAG, 2: AI reaction delay in frames, ≥1.
- AI_DEADZONE, 8: AI hold band in pixels.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame; all motion happens only on this pulse.
- play_en  in  1  0 freezes the paddle (IDLE).
- ai_ctrl  in  1  1 selects AI, 0 selects player.
- btn_up, btn_down  in  1 each  player controls, level-sensitive.
- ball_y  in  9  ball top Y.
- ball_toward  in  1  1 when the ball is moving toward this paddle.
- outX  out  10  paddle X, constant after reset.
- outY  out  9  paddle Y.
- moving  out  1  paddle moved on the last tick.
- dir_down  out  1  direction of the last move.
- at_limit  out  1  outY is 0 or Y_MAX.

## Operation
- Derived constants:
  - Y_MAX = SCREEN_H − PAD_LEN (416).
  - Y_CTR = Y_MAX/2 (208).
  - X_POS = LEFT ? 0 : SCREEN_W − PAD_W (632).
- Reset values:
  - outX = X_POS, outY = Y_CTR.
  - moving = 0, dir_down = 0.
  - ramp step = 1.
  - Every lag-pipeline stage holds SCREEN_H/2 (240).
  - State = IDLE.
- States, evaluated on each frame_tick:
  - IDLE when play_en = 0.
  - PLAYER when play_en = 1 and ai_ctrl = 0.
  - AI_TRACK when play_en = 1, ai_ctrl = 1 and ball_toward = 1.
  - AI_RETURN when play_en = 1, ai_ctrl = 1 and ball_toward = 0.
- The state is re-decided on every frame_tick. Mode inputs that change between ticks have no effect until the next tick.
- IDLE: no motion; moving = 0; ramp step resets to 1.
- PLAYER:
  - Exactly one button held: move by the ramp step, then increment step (saturate at SPEED).
  - Neither button, or both held: no motion; step resets to 1.
  - A direction reversal moves by 1, then ramps from there.
- Lag pipeline: an AI_LAG-deep shift register of ball_y, shifted on every frame_tick in all states. The AI sees the sample from AI_LAG ticks earlier.
- AI target:
  - AI_TRACK: target = clamp(lagged_y − PAD_LEN/2, 0, Y_MAX). Use signed or widened arithmetic; no underflow wrap.
  - AI_RETURN: target = Y_CTR.
- AI motion:
  - If |target − outY| ≤ AI_DEADZONE, hold (moving = 0).
  - Otherwise move toward the target by min(SPEED, |target − outY|). There is no overshoot and no ramp.
  - Entering an AI state resets the ramp step to 1.
- All moves saturate at 0 and Y_MAX. A move clipped by saturation counts as moving only if outY actually changed.
- On every tick in which outY changed, dir_down = 1 for increasing Y. Otherwise dir_down holds its value.

## Timing
- All outputs are registered.
- outY, moving, dir_down and at_limit update on the clk edge that samples frame_tick = 1, so they are visible the following cycle.
- With frame_tick = 0, all state holds except that the next mode is pending.
- Effective AI latency: a ball_y change affects motion AI_LAG ticks later.
- reset asserted on any cycle, including one coincident with frame_tick, wins and restores all reset values on that edge.
- frame_tick asserted on consecutive cycles is legal; each pulse is a separate step.

## Structure
- Shared pong package holds:
  - Screen dimensions and coordinate widths (X 10 b, Y 9 b).
  - The state enum {IDLE, PLAYER, AI_TRACK, AI_RETURN}.
- Sub-module paddle_ai_target contains the lag pipeline, target clamp and dead-zone compare. The top level contains the FSM, ramp and saturating position register.

## Test plan
- Reset, both LEFT values → outX = 0 / 632, outY = 208, moving = 0, at_limit = 0.
- PLAYER, btn_up held 10 ticks from 208 → steps 1, 2, 3, 4, 4 …, outY = 174. Then release and hold btn_down 1 tick → outY = 175.
- PLAYER, btn_down held from outY = 410 → 411, 413, 416, 416. at_limit = 1 from reaching 416; moving = 0 on the stuck tick. Both buttons held → no motion.
- AI_TRACK, ball_y = 400 from reset, AI_LAG = 2 → ticks 1–2 hold (target 208). Then +4 per tick to 368 within the dead zone: stops at 360 (|8| ≤ 8).
- Dead zone: outY = 208, lagged ball_y = 250 (target 218) → moves to 212, then holds. ball_toward = 0 → returns toward 208, holding within ±8.
- Reset asserted together with frame_tick mid-move → outY = 208 next cycle, pipeline reloaded with 240, state IDLE.
